// File: rtl/gb_serial_pkg.sv
// Shared definitions for the Game Boy serial link port: register addresses,
// the transfer state encoding and the SC read-back format.
package gb_serial_pkg;

  localparam logic [15:0] ADDR_SB = 16'hFF01;
  localparam logic [15:0] ADDR_SC = 16'hFF02;

  // Bit position of the serial request in the interrupt flag register.
  localparam int unsigned IRQ_SERIAL_BIT = 3;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_XFER_INT,
    SER_XFER_EXT
  } ser_state_t;

  // SC reads back with the unimplemented bits set.
  function automatic logic [7:0] sc_read(input logic sc7, input logic sc0);
    return {sc7, 6'b111111, sc0};
  endfunction

endpackage

// File: rtl/gb_serial_clkgen.sv
// Serial bit timing: internal divider for the local clock and a synchronizer
// with edge detect for the externally supplied clock.
module gb_serial_clkgen #(
  parameter int unsigned BIT_PERIOD = 128
) (
  input  logic clk,
  input  logic reset,
  input  logic i_int_en,
  input  logic i_ext_en,
  input  logic i_restart,
  input  logic sclk_i,
  output logic o_fall_strobe,
  output logic o_rise_strobe,
  output logic o_sclk
);

  localparam int unsigned DivW = $clog2(BIT_PERIOD);
  localparam logic [DivW-1:0] DivLast = DivW'(BIT_PERIOD - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(BIT_PERIOD / 2 - 1);

  if ((BIT_PERIOD < 4) || (BIT_PERIOD % 2 != 0)) begin : g_bad_period
    $error("BIT_PERIOD must be even and at least 4");
  end

  logic [DivW-1:0] r_div;
  // [0] first sync flop, [1] synchronized level, [2] previous synchronized level
  logic [2:0]      r_sync;
  logic            w_ext_rise;
  logic            w_ext_fall;

  // Divider runs only while an internal-clock transfer is active; a start clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div <= '0;
    end else if (i_restart || !i_int_en || (r_div == DivLast)) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // External clock synchronizer; idles high so no edge is seen out of reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync <= 3'b111;
    end else begin
      r_sync <= {r_sync[1:0], sclk_i};
    end
  end

  assign w_ext_rise = r_sync[1] & ~r_sync[2];
  assign w_ext_fall = ~r_sync[1] & r_sync[2];

  // Internal mode: fall marks the bit boundary, rise marks the half-period sample point.
  always_comb begin
    o_fall_strobe = 1'b0;
    o_rise_strobe = 1'b0;
    if (i_int_en) begin
      o_fall_strobe = (r_div == DivLast);
      o_rise_strobe = (r_div == DivHalf);
    end else if (i_ext_en) begin
      o_fall_strobe = w_ext_fall;
      o_rise_strobe = w_ext_rise;
    end
  end

  // Low for the first half of each internal bit, otherwise parked high.
  assign o_sclk = ~i_int_en | (r_div > DivHalf);

endmodule

// File: rtl/gb_serial.sv
// Game Boy serial link port: SB/SC register decode, MSB-first byte shifter,
// transfer-complete interrupt pulse and a transmitted-byte log strobe.
module gb_serial
  import gb_serial_pkg::*;
#(
  parameter int unsigned BIT_PERIOD = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_i,
  input  logic [15:0] addr,
  input  logic        wren,
  output logic [7:0]  data_o,
  output logic        irq_serial,
  output logic        sout,
  input  logic        sin,
  output logic        sclk_o,
  input  logic        sclk_i,
  output logic [7:0]  tx_byte,
  output logic        tx_valid
);

  ser_state_t r_state;
  logic [7:0] r_sb;
  logic       r_sc7;
  logic       r_sc0;
  logic [2:0] r_cnt;
  logic       r_sout;
  logic       r_irq;
  logic [7:0] r_tx_byte;

  logic w_sb_wr;
  logic w_sc_wr;
  logic w_restart;
  logic w_int_en;
  logic w_ext_en;
  logic w_fall;
  logic w_rise;
  logic w_done;

  assign w_sb_wr   = wren && (addr == ADDR_SB);
  assign w_sc_wr   = wren && (addr == ADDR_SC);
  assign w_restart = w_sc_wr && data_i[7];
  assign w_int_en  = (r_state == SER_XFER_INT);
  assign w_ext_en  = (r_state == SER_XFER_EXT);

  gb_serial_clkgen #(
    .BIT_PERIOD(BIT_PERIOD)
  ) u_clkgen (
    .clk          (clk),
    .reset        (reset),
    .i_int_en     (w_int_en),
    .i_ext_en     (w_ext_en),
    .i_restart    (w_restart),
    .sclk_i       (sclk_i),
    .o_fall_strobe(w_fall),
    .o_rise_strobe(w_rise),
    .o_sclk       (sclk_o)
  );

  // Internal mode finishes at the end of bit 7; external at the 8th sampling edge.
  assign w_done = (r_cnt == 3'd7) && ((w_int_en && w_fall) || (w_ext_en && w_rise));

  // Transfer FSM, shifter and registered outputs; an SC write outranks everything else.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= SER_IDLE;
      r_sb      <= 8'h00;
      r_sc7     <= 1'b0;
      r_sc0     <= 1'b0;
      r_cnt     <= 3'd0;
      r_sout    <= 1'b1;
      r_irq     <= 1'b0;
      r_tx_byte <= 8'h00;
    end else begin
      r_irq <= 1'b0;
      if (w_sc_wr) begin
        r_sc7 <= data_i[7];
        r_sc0 <= data_i[0];
        if (data_i[7]) begin
          r_cnt     <= 3'd0;
          r_tx_byte <= r_sb;
          if (data_i[0]) begin
            r_state <= SER_XFER_INT;
            r_sout  <= r_sb[7];
          end else begin
            r_state <= SER_XFER_EXT;
            r_sout  <= 1'b1;
          end
        end else if (r_state != SER_IDLE) begin
          // Abort keeps the partially shifted SB.
          r_state <= SER_IDLE;
          r_sout  <= 1'b1;
          r_cnt   <= 3'd0;
        end
      end else begin
        if (w_sb_wr && (r_state == SER_IDLE)) begin
          r_sb <= data_i;
        end
        unique case (r_state)
          SER_XFER_INT: begin
            if (w_rise) begin
              r_sb <= {r_sb[6:0], sin};
            end
            if (w_fall) begin
              r_cnt  <= r_cnt + 3'd1;
              r_sout <= r_sb[7];
            end
          end
          SER_XFER_EXT: begin
            if (w_fall) begin
              r_sout <= r_sb[7];
            end
            if (w_rise) begin
              r_sb  <= {r_sb[6:0], sin};
              r_cnt <= r_cnt + 3'd1;
            end
          end
          default: ;
        endcase
        if (w_done) begin
          r_state <= SER_IDLE;
          r_sc7   <= 1'b0;
          r_cnt   <= 3'd0;
          r_sout  <= 1'b1;
          r_irq   <= 1'b1;
        end
      end
    end
  end

  // Register read mux; unmapped addresses float high like an open bus.
  always_comb begin
    data_o = 8'hFF;
    if (addr == ADDR_SB) begin
      data_o = r_sb;
    end else if (addr == ADDR_SC) begin
      data_o = sc_read(r_sc7, r_sc0);
    end
  end

  assign irq_serial = r_irq;
  assign tx_valid   = r_irq;
  assign tx_byte    = r_tx_byte;
  assign sout       = r_sout;

endmodule

// File: doc/gb_serial.md
Name: gb_serial

Overview:
- Game Boy serial link port. Sits on the CPU data bus beside the timer and decodes SB (FF01) and SC (FF02).
- Shifts one byte out on sout and one byte in from sin, MSB first, using the internal clock or an external clock.
- On completion it raises a one-cycle irq_serial, which the system logic ORs into IF bit 3.
- It also emits tx_byte/tx_valid so benches can log serial output without polling memory.

Parameters:
- BIT_PERIOD, 128: clk cycles per serial bit in internal-clock mode (8192 Hz at M-cycle clk). Must be even and >= 4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- data_i  input  8  CPU write data.
- addr  input  16  CPU bus address.
- wren  input  1  CPU write strobe; a write is accepted on the clk edge where it is high.
- data_o  output  8  register read data (combinational from addr).
- irq_serial  output  1  one-cycle transfer-complete pulse.
- sout  output  1  serial data out.
- sin  input  1  serial data in; tie to 1 when unconnected.
- sclk_o  output  1  serial clock out, internal mode only.
- sclk_i  input  1  external serial clock, asynchronous.
- tx_byte  output  8  byte that was transmitted.
- tx_valid  output  1  one-cycle pulse, coincident with irq_serial.

Behaviour:
- Reset (reset==0 at an edge) sets:
  - SB=00, SC[7]=0, SC[0]=0, state IDLE.
  - sout=1, sclk_o=1.
  - irq_serial=0, tx_valid=0, tx_byte=00.
  - Bit counter and divider cleared.
- Reset asserted mid-transfer aborts the transfer with no irq.
- Reads:
  - addr FF01 -> SB.
  - addr FF02 -> {SC[7], 6'b111111, SC[0]}.
  - Any other addr -> FF.
- Writes to SB:
  - Accepted in IDLE.
  - Ignored while a transfer is active.
- Writes to SC: SC[7]<=data_i[7], SC[0]<=data_i[0].
  - data_i[7]=1 in any state (re)starts a transfer:
    - Bit counter=0, divider=0.
    - tx_byte latches the current SB.
    - Next state is XFER_INT if data_i[0]=1, else XFER_EXT.
  - data_i[7]=0 while busy aborts to IDLE. SB keeps its partially shifted value; no irq.
- States:
  - IDLE: sclk_o=1, sout=1.
  - XFER_INT (internal clock), each bit lasts BIT_PERIOD cycles:
    - First half: sclk_o=0, sout=SB[7] (falling edge presents data).
    - At the half-period edge: sclk_o->1, SB<={SB[6:0], sin}.
    - After 8 bits: SC[7]<=0, state IDLE.
    - With the start write accepted at edge E0, irq_serial and tx_valid are high exactly in the cycle after edge E0+8*BIT_PERIOD.
  - XFER_EXT (external clock):
    - sclk_i passes through a 2-flop synchronizer plus edge detect.
    - Synchronized falling edge: sout<=SB[7].
    - Synchronized rising edge: SB shifts in sin and the bit counter increments.
    - The 8th rising edge completes the transfer as in internal mode; irq fires on the cycle after that shift is registered.
    - sclk_o holds 1.
    - No timeout: the block waits indefinitely.
- Bit counter is 3 bits; it wraps 7->0 only at completion.
- A CPU write to SC landing on the same edge as completion takes priority: the new write's effect stands and the irq is suppressed.
- irq_serial is never held high for more than one cycle.

Decomposition:
- Shared package gb_serial_pkg:
  - ADDR_SB=16'hFF01, ADDR_SC=16'hFF02.
  - typedef enum logic [1:0] {SER_IDLE, SER_XFER_INT, SER_XFER_EXT} ser_state_t.
  - IRQ_SERIAL_BIT=3.
- Sub-module gb_serial_clkgen:
  - Internal divider (counter 0..BIT_PERIOD-1).
  - Produces fall_strobe/rise_strobe plus sclk_o.
  - Handles the external-clock synchronizer/edge detect, selected by SC[0].

Test Plan:
- Internal mode with BIT_PERIOD=128 and sin tied 1: write SB=41 then SC=81 -> after 1024 cycles:
  - irq_serial and tx_valid each pulse 1 cycle; tx_byte=41.
  - SB reads FF; SC reads 7F.
  - sout shows 0,1,0,0,0,0,0,1.
- Loopback (sin=sout) with SB=A5, SC=81 -> SB reads A5 after completion; exactly 8 sclk_o low pulses of 64 cycles each.
- External mode: SB=3C, SC=80, then drive 8 sclk_i pulses with sin=0 -> SB=00, SC reads 7E, irq pulses once; no irq before the 8th rising edge.
- Abort: SC=81, then after 300 cycles write SC=01 -> state IDLE, no irq within 2000 cycles, SC reads 7F, SB partially shifted.
- Write SB=55 mid-transfer -> ignored; tx_byte still equals the byte latched at start.
- Reset: drive reset=0 during a transfer for one edge -> SB=00, SC reads 7E, sout=1, sclk_o=1, no irq; a subsequent SC=81 completes normally.
